// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 256Kx16 asynchronous SRAM between a read-only,
// high-priority pixel fetcher (port A) and a read/write CPU bridge (port B).
// Each access runs IDLE -> RD/WR for ACCESS_CYCLES cycles -> IDLE. All SRAM
// pins, grants, rvalid and rdata come straight from flops.
// Optional feature: define SRAM_ARB_ANTI_STARVE_EN to let B win after
// STARVE_LIMIT consecutive A grants that were made while B was waiting.
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_req,
    input  logic [17:0] a_addr,
    output logic        a_gnt,
    output logic [15:0] a_rdata,
    output logic        a_rvalid,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [17:0] b_addr,
    input  logic [15:0] b_wdata,
    input  logic [1:0]  b_be,
    output logic        b_gnt,
    output logic [15:0] b_rdata,
    output logic        b_rvalid,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_params
        $error("sram_arbiter: ACCESS_CYCLES or STARVE_LIMIT out of range");
    end

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        grant_a, grant_b, starve_hit;
    logic        owner_b;                 // 1 = current access belongs to B
    logic [1:0]  lane_n, lane_nxt;        // active-low byte lanes of current access
    logic [15:0] wdata_q;
    logic        dq_oe, dq_oe_nxt;
    logic        ce_nxt, oe_nxt, we_nxt, ub_nxt, lb_nxt;
    logic        rd_done;

    assign SRAM_DQ = dq_oe ? wdata_q : 16'hzzzz;

`ifdef SRAM_ARB_ANTI_STARVE_EN
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0] starve;

    assign starve_hit = (starve == STARVE_MAX);

    // Count A grants that bypassed a waiting B; any B grant or uncontended A grant clears it
    always_ff @(posedge clk) begin
        if (!reset_n)     starve <= '0;
        else if (grant_b) starve <= '0;
        else if (grant_a) starve <= b_req ? starve + 4'd1 : 4'd0;
    end
`else
    assign starve_hit = 1'b0;
`endif

    // Arbitration only happens in IDLE; A wins unless B has been starved too long
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            grant_a = a_req && !(b_req && starve_hit);
            grant_b = b_req && !grant_a;
        end
    end

    // State register and access-cycle counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: IDLE launches an access, RD/WR run for ACCESS_CYCLES cycles
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (grant_a)      state_nxt = RD;
                else if (grant_b) state_nxt = b_we ? WR : RD;
            end
            RD, WR: begin
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: next-cycle strobe values derived from the upcoming state so the pins can be registered.
    // WE_N rises in the last WR cycle while DQ stays driven to give data hold.
    always_comb begin
        lane_nxt = lane_n;
        if (grant_a)      lane_nxt = 2'b00;
        else if (grant_b) lane_nxt = ~b_be;
        ce_nxt    = 1'b1;
        oe_nxt    = 1'b1;
        we_nxt    = 1'b1;
        ub_nxt    = 1'b1;
        lb_nxt    = 1'b1;
        dq_oe_nxt = 1'b0;
        rd_done   = (state == RD) && (cnt == LAST);
        if (state_nxt != IDLE) begin
            ce_nxt = 1'b0;
            ub_nxt = lane_nxt[1];
            lb_nxt = lane_nxt[0];
            if (state_nxt == RD) begin
                oe_nxt = 1'b0;
            end else begin
                dq_oe_nxt = 1'b1;
                we_nxt    = (cnt_nxt == LAST);
            end
        end
    end

    // Latch the winner's address, write data and ownership at grant time
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_b   <= 1'b0;
            SRAM_ADDR <= '0;
            wdata_q   <= '0;
            lane_n    <= 2'b11;
        end else begin
            lane_n <= lane_nxt;
            if (grant_a) begin
                owner_b   <= 1'b0;
                SRAM_ADDR <= a_addr;
            end else if (grant_b) begin
                owner_b   <= 1'b1;
                SRAM_ADDR <= b_addr;
                wdata_q   <= b_wdata;
            end
        end
    end

    // Registered pins, grant pulses and read return
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            dq_oe     <= 1'b0;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            SRAM_CE_N <= ce_nxt;
            SRAM_OE_N <= oe_nxt;
            SRAM_WE_N <= we_nxt;
            SRAM_UB_N <= ub_nxt;
            SRAM_LB_N <= lb_nxt;
            dq_oe     <= dq_oe_nxt;
            a_gnt     <= grant_a;
            b_gnt     <= grant_b;
            a_rvalid  <= rd_done && !owner_b;
            b_rvalid  <= rd_done && owner_b;
            if (rd_done && !owner_b) a_rdata <= SRAM_DQ;
            if (rd_done && owner_b)  b_rdata <= SRAM_DQ;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: one instance with ACCESS_CYCLES=2 on a behavioural
// SRAM, one with ACCESS_CYCLES=4 on a pattern-returning SRAM. Expected grant
// and read-return events are queued at issue time and checked by a monitor.
module tb_sram_arbiter;

  typedef struct {int cyc; logic [15:0] d;} rv_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  logic reset_n;
  // instance with ACCESS_CYCLES=2
  logic a_req, a_gnt, a_rvalid, b_req, b_we, b_gnt, b_rvalid;
  logic [17:0] a_addr, b_addr, sram_addr;
  logic [15:0] a_rdata, b_rdata, b_wdata;
  logic [1:0] b_be;
  logic ce_n, oe_n, we_n, ub_n, lb_n;
  wire  [15:0] dq;
  // instance with ACCESS_CYCLES=4
  logic a4_req, a4_gnt, a4_rvalid, b4_req, b4_we, b4_gnt, b4_rvalid;
  logic [17:0] a4_addr, b4_addr, sram4_addr;
  logic [15:0] a4_rdata, b4_rdata, b4_wdata;
  logic [1:0] b4_be;
  logic ce4_n, oe4_n, we4_n, ub4_n, lb4_n;
  wire  [15:0] dq4;

  sram_arbiter #(.ACCESS_CYCLES(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .SRAM_DQ(dq), .SRAM_ADDR(sram_addr), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n));

  sram_arbiter #(.ACCESS_CYCLES(4), .STARVE_LIMIT(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .a_req(a4_req), .a_addr(a4_addr), .a_gnt(a4_gnt), .a_rdata(a4_rdata), .a_rvalid(a4_rvalid),
    .b_req(b4_req), .b_we(b4_we), .b_addr(b4_addr), .b_wdata(b4_wdata), .b_be(b4_be),
    .b_gnt(b4_gnt), .b_rdata(b4_rdata), .b_rvalid(b4_rvalid),
    .SRAM_DQ(dq4), .SRAM_ADDR(sram4_addr), .SRAM_CE_N(ce4_n), .SRAM_OE_N(oe4_n),
    .SRAM_WE_N(we4_n), .SRAM_UB_N(ub4_n), .SRAM_LB_N(lb4_n));

  function automatic logic [15:0] init_word(input int i);
    return 16'hC000 ^ 16'(i * 291);
  endfunction

  // behavioural SRAM for the first instance: byte-lane writes, full-word reads
  logic [15:0] mem [0:63];
  assign dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (cyc < 2) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (!ce_n && !we_n) begin
      if (!ub_n) mem[sram_addr[5:0]][15:8] <= dq[15:8];
      if (!lb_n) mem[sram_addr[5:0]][7:0]  <= dq[7:0];
    end
  end

  // second SRAM returns an address-derived pattern
  assign dq4 = (!ce4_n && !oe4_n) ? (sram4_addr[15:0] ^ 16'h5A5A) : 16'hzzzz;

  logic [15:0] exp_mem [0:63];
  int q_agnt[$], q_bgnt[$], q_a4gnt[$], q_b4gnt[$];
  rv_t q_arv[$], q_brv[$], q_a4rv[$];
  rv_t mon_e;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // monitor: every grant / rvalid pulse must match the head of its queue
  always @(negedge clk) begin
    if (a_gnt) begin
      check("a_gnt pending", 32'(q_agnt.size() != 0), 1);
      if (q_agnt.size() != 0) check("a_gnt cycle", cyc, q_agnt.pop_front());
    end
    if (b_gnt) begin
      check("b_gnt pending", 32'(q_bgnt.size() != 0), 1);
      if (q_bgnt.size() != 0) check("b_gnt cycle", cyc, q_bgnt.pop_front());
    end
    if (a_rvalid) begin
      check("a_rvalid pending", 32'(q_arv.size() != 0), 1);
      if (q_arv.size() != 0) begin
        mon_e = q_arv.pop_front();
        check("a_rvalid cycle", cyc, mon_e.cyc);
        check("a_rdata", a_rdata, mon_e.d);
      end
    end
    if (b_rvalid) begin
      check("b_rvalid pending", 32'(q_brv.size() != 0), 1);
      if (q_brv.size() != 0) begin
        mon_e = q_brv.pop_front();
        check("b_rvalid cycle", cyc, mon_e.cyc);
        check("b_rdata", b_rdata, mon_e.d);
      end
    end
    if (a4_gnt) begin
      check("a4_gnt pending", 32'(q_a4gnt.size() != 0), 1);
      if (q_a4gnt.size() != 0) check("a4_gnt cycle", cyc, q_a4gnt.pop_front());
    end
    if (b4_gnt) begin
      check("b4_gnt pending", 32'(q_b4gnt.size() != 0), 1);
      if (q_b4gnt.size() != 0) check("b4_gnt cycle", cyc, q_b4gnt.pop_front());
    end
    if (a4_rvalid) begin
      check("a4_rvalid pending", 32'(q_a4rv.size() != 0), 1);
      if (q_a4rv.size() != 0) begin
        mon_e = q_a4rv.pop_front();
        check("a4_rvalid cycle", cyc, mon_e.cyc);
        check("a4_rdata", a4_rdata, mon_e.d);
      end
    end
    if (b4_rvalid) check("b4_rvalid on write", 1, 0);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic a_op(input logic [17:0] ad);
    int g;
    g = 0;
    a_req = 1'b1; a_addr = ad;
    do begin tick(1); g++; end while (!a_gnt && g < 100);
    if (!a_gnt) check("a_gnt timeout", 0, 1);
    a_req = 1'b0;
  endtask

  task automatic b_op(input logic we, input logic [17:0] ad, input logic [15:0] wd, input logic [1:0] be);
    int g;
    g = 0;
    b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd; b_be = be;
    do begin tick(1); g++; end while (!b_gnt && g < 100);
    if (!b_gnt) check("b_gnt timeout", 0, 1);
    b_req = 1'b0;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd, input logic [1:0] be);
    return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
  endfunction

  task automatic push_rv(input bit port_b, input int c, input logic [15:0] d);
    rv_t e;
    e.cyc = c; e.d = d;
    if (port_b) q_brv.push_back(e); else q_arv.push_back(e);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int t;
  rv_t e4;

  initial begin
    reset_n = 1'b0;
    a_req = 0; a_addr = '0; b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    a4_req = 0; a4_addr = '0; b4_req = 0; b4_we = 0; b4_addr = '0; b4_wdata = '0; b4_be = '0;
    for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
    tick(3);
    reset_n = 1'b1;
    tick(1);
    check("reset strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    check("reset strobes 4", {ce4_n, oe4_n, we4_n, ub4_n, lb4_n}, 5'h1F);
    check("reset sram_addr", sram_addr, 0);
    check("reset pulses", {a_gnt, b_gnt, a_rvalid, b_rvalid}, 0);
    check("reset rdata", {a_rdata, b_rdata}, 0);

    // B full write then readback
    t = cyc; q_bgnt.push_back(t + 1); exp_mem[18] = 16'hBEEF;
    b_op(1'b1, 18'h00012, 16'hBEEF, 2'b11);
    check("wr1 strobes T+1", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b01000);
    tick(1);
    check("wr1 strobes T+2", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b01100);
    check("wr1 dq hold", dq, 16'hBEEF);
    tick(1);
    check("wr1 idle strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);

    t = cyc; q_bgnt.push_back(t + 1); push_rv(1, t + 3, exp_mem[18]);
    b_op(1'b0, 18'h00012, 16'h0000, 2'b11);
    tick(2);

    // lower-byte write merges into existing word
    t = cyc; q_bgnt.push_back(t + 1); exp_mem[18] = merge(exp_mem[18], 16'h12AB, 2'b01);
    b_op(1'b1, 18'h00012, 16'h12AB, 2'b01);
    check("wr be01 lanes", {we_n, ub_n, lb_n}, 3'b010);
    tick(2);
    t = cyc; q_bgnt.push_back(t + 1); push_rv(1, t + 3, 16'hBEAB);
    b_op(1'b0, 18'h00012, 16'h0000, 2'b11);
    tick(2);

    // be=00 write: full cycle, no lane strobed
    t = cyc; q_bgnt.push_back(t + 1);
    b_op(1'b1, 18'h00012, 16'h0000, 2'b00);
    check("wr be00 lanes", {ce_n, we_n, ub_n, lb_n}, 4'b0011);
    tick(2);
    t = cyc; q_bgnt.push_back(t + 1); push_rv(1, t + 3, 16'hBEAB);
    b_op(1'b0, 18'h00012, 16'h0000, 2'b11);
    tick(2);

    // lone A read
    t = cyc; q_agnt.push_back(t + 1); push_rv(0, t + 3, exp_mem[5]);
    a_op(18'h00005);
    check("a rd strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b00100);
    tick(2);

    // simultaneous A and B reads: A first, B right after
    t = cyc;
    q_agnt.push_back(t + 1); push_rv(0, t + 3, exp_mem[6]);
    q_bgnt.push_back(t + 4); push_rv(1, t + 6, exp_mem[18]);
    fork
      a_op(18'h00006);
      b_op(1'b0, 18'h00012, 16'h0000, 2'b11);
    join
    tick(2);

    // A held continuously with a B read pending
    t = cyc;
`ifdef SRAM_ARB_ANTI_STARVE_EN
    for (int k = 0; k < 4; k++) begin q_agnt.push_back(t + 1 + 3*k); push_rv(0, t + 3 + 3*k, exp_mem[5]); end
    q_bgnt.push_back(t + 13); push_rv(1, t + 15, exp_mem[18]);
    for (int k = 0; k < 16; k++) begin q_agnt.push_back(t + 16 + 3*k); push_rv(0, t + 18 + 3*k, exp_mem[5]); end
`else
    for (int k = 0; k < 20; k++) begin q_agnt.push_back(t + 1 + 3*k); push_rv(0, t + 3 + 3*k, exp_mem[5]); end
    q_bgnt.push_back(t + 61); push_rv(1, t + 63, exp_mem[18]);
`endif
    fork
      begin
        int n, g;
        n = 0; g = 0;
        a_req = 1'b1; a_addr = 18'h00005;
        while (n < 20 && g < 200) begin tick(1); g++; if (a_gnt) n++; end
        if (n < 20) check("a stream timeout", n, 20);
        a_req = 1'b0;
      end
      b_op(1'b0, 18'h00012, 16'h0000, 2'b11);
    join
    tick(5);

    // reset during the first RD cycle abandons the access
    t = cyc; q_agnt.push_back(t + 1);
    a_req = 1'b1; a_addr = 18'h00007;
    tick(1);
    a_req = 1'b0; reset_n = 1'b0;
    tick(1);
    check("mid-reset strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    check("mid-reset rvalid", a_rvalid, 0);
    reset_n = 1'b1;
    tick(5);

    // ACCESS_CYCLES=4: back-to-back A reads every 5 cycles
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      q_a4gnt.push_back(t + 1 + 5*k);
      e4.cyc = t + 5 + 5*k; e4.d = 16'(18'h00100 + 18'(k)) ^ 16'h5A5A;
      q_a4rv.push_back(e4);
    end
    begin
      int n, g;
      n = 0; g = 0;
      a4_req = 1'b1; a4_addr = 18'h00100;
      while (n < 4 && g < 100) begin
        tick(1); g++;
        if (a4_gnt) begin n++; a4_addr = 18'h00100 + 18'(n); end
      end
      if (n < 4) check("a4 stream timeout", n, 4);
      a4_req = 1'b0;
    end
    tick(5);

    // ACCESS_CYCLES=4 write: WE_N low for three cycles, high in the fourth
    t = cyc; q_b4gnt.push_back(t + 1);
    b4_req = 1'b1; b4_we = 1'b1; b4_addr = 18'h00020; b4_wdata = 16'h1234; b4_be = 2'b11;
    tick(1);
    b4_req = 1'b0;
    check("w4 cyc1", {ce4_n, oe4_n, we4_n}, 3'b010);
    tick(1);
    check("w4 cyc2", {ce4_n, oe4_n, we4_n}, 3'b010);
    tick(1);
    check("w4 cyc3", {ce4_n, oe4_n, we4_n}, 3'b010);
    tick(1);
    check("w4 cyc4", {ce4_n, oe4_n, we4_n}, 3'b011);
    check("w4 dq hold", dq4, 16'h1234);
    tick(1);
    check("w4 idle", {ce4_n, oe4_n, we4_n}, 3'b111);
    tick(3);

    check("events drained", q_agnt.size() + q_bgnt.size() + q_arv.size() + q_brv.size()
          + q_a4gnt.size() + q_b4gnt.size() + q_a4rv.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

- Shares the board's 256K×16 asynchronous SRAM between two requesters: port A, a read-only, high-priority video pixel fetcher, and port B, a read/write CPU-side bridge.
- Sequences every SRAM access with registered control strobes and performs byte-lane masking.
- Returns read data with a one-cycle valid pulse.
- Sits between the Avalon-side masters and the top-level SRAM pins (SRAM_DQ/ADDR/CE_N/OE_N/WE_N/UB_N/LB_N).

## Interface
Parameters:
- ACCESS_CYCLES, 2: cycles per SRAM access; legal range 2..15.
- STARVE_LIMIT, 4: consecutive A grants tolerated while B waits; legal range 1..15. Used only with the anti-starvation feature.

Ports:
- clk  in  1  system clock (50 MHz); all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- a_req  in  1  port A read request; hold until a_gnt seen.
- a_addr  in  18  port A word address.
- a_gnt  out  1  one-cycle grant pulse for A.
- a_rdata  out  16  port A read data.
- a_rvalid  out  1  one-cycle pulse; a_rdata valid.
- b_req  in  1  port B request; hold until b_gnt seen.
- b_we  in  1  1 = write, 0 = read.
- b_addr  in  18  port B word address.
- b_wdata  in  16  port B write data.
- b_be  in  2  byte enables; [1] = upper byte, [0] = lower byte.
- b_gnt  out  1  one-cycle grant pulse for B.
- b_rdata  out  16  port B read data.
- b_rvalid  out  1  one-cycle pulse on B read completion only.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM address.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes.

## Operation
- States: IDLE, RD, WR. A 4-bit counter cnt runs inside RD/WR.
- IDLE:
  - CE_N, OE_N, WE_N, UB_N, LB_N all 1; DQ tri-stated; SRAM_ADDR holds its last value.
  - Arbitration runs here. Fixed priority: A over B.
  - Winner: address, data and byte enables latched; gnt pulse registered for the winner; next state RD (A, or B with b_we=0) or WR (B with b_we=1).
- RD:
  - CE_N=0, OE_N=0, WE_N=1; DQ tri-stated.
  - Byte lanes: A uses UB_N=LB_N=0; B uses UB_N=~b_be[1], LB_N=~b_be[0].
  - Lasts ACCESS_CYCLES cycles.
  - On the edge ending the last RD cycle: SRAM_DQ captured into the owner's rdata, owner's rvalid set for one cycle, state returns to IDLE.
- WR:
  - CE_N=0, OE_N=1; DQ driven with latched wdata for all ACCESS_CYCLES cycles; byte lanes as B read.
  - WE_N=0 for the first ACCESS_CYCLES−1 cycles and 1 in the last cycle, giving data hold with the bus still driven.
  - Then IDLE. No rvalid for writes.
- IDLE between accesses is the bus turnaround; DQ is never driven in IDLE or RD.
- Other port's requests while busy are ignored until IDLE; requesters keep req asserted.
- Byte enable b_be=00 on write: full cycle runs, no lane written (UB_N=LB_N=1).
- rdata holds its value until the next read completion for that port.

## Timing
- Request sampled in IDLE cycle T. gnt high in cycle T+1, the first RD/WR cycle.
- Requester may change req/addr/data from cycle T+2.
- Read: rvalid high in cycle T+1+ACCESS_CYCLES. Earliest next grant in that same cycle (IDLE).
- Access period: ACCESS_CYCLES+1 cycles per read or write.
- All SRAM outputs, gnt, rvalid and rdata are registered (no combinational paths from req).
- Reset values: state IDLE, cnt 0, SRAM_ADDR 0, all strobes 1, DQ tri-stated, gnt/rvalid 0, rdata 0, starvation counter 0.
- Reset mid-access: the access is abandoned at the next edge; no rvalid; a partial write may have occurred.

## Configuration
- Macro SRAM_ARB_ANTI_STARVE_EN.
- Defined:
  - A starvation counter increments on each A grant made while b_req=1.
  - The counter clears on a B grant, or on an A grant made while b_req=0.
  - When the counter equals STARVE_LIMIT and both requests are present, B wins and the counter clears.
- Undefined: pure fixed priority; B may starve indefinitely; no counter logic.

## Test plan
- ACCESS_CYCLES=2, B write 0x00012 ← 0xBEEF, be=11, then B read 0x00012:
  - write: b_gnt at T+1; WE_N=0 in cycle T+1 only.
  - read: b_rvalid at T+3 with 0xBEEF.
- B write 0x12AB with be=01 over 0xBEEF: UB_N=1, LB_N=0 during WR; readback 0xBEAB.
- a_req and b_req (read) rise in the same IDLE cycle:
  - a_gnt at T+1, a_rvalid at T+3;
  - b_gnt at T+4, b_rvalid at T+6.
- a_req held high continuously, B read pending, STARVE_LIMIT=4:
  - without the macro, no b_gnt in 20 accesses;
  - with the macro, b_gnt immediately after the 4th a_gnt.
- reset_n=0 during the first RD cycle: next cycle all strobes 1, DQ tri-stated, no rvalid ever issued for that access.
- ACCESS_CYCLES=4: WE_N low for 3 cycles per write; read rvalid at T+5; back-to-back A reads granted every 5 cycles.
